// File: rtl/rotary_scanner_pkg.sv
// Shared types and constants for the rotary encoder scanner: event record layout,
// INFO byte bit positions and CTRL register bits.
package rotary_scanner_pkg;

  localparam int MAX_CH      = 8;
  localparam int CH_W        = 3;
  // Queue entries carry the counter value at this fixed width; narrower counters are zero-extended.
  localparam int EVT_VALUE_W = 16;

  localparam int INFO_VALID_BIT = 7;
  localparam int INFO_TYPE_BIT  = 6;
  localparam int INFO_DIR_BIT   = 5;
  localparam int INFO_SW_BIT    = 4;
  localparam int INFO_CH_LSB    = 0;

  localparam int CTRL_INT_EN_BIT = 0;
  localparam int CTRL_FLUSH_BIT  = 1;

  typedef struct packed {
    logic                   evt_type;
    logic                   dir;
    logic                   sw;
    logic [CH_W-1:0]        ch;
    logic [EVT_VALUE_W-1:0] value;
  } evt_t;

  function automatic logic [7:0] info_byte(input logic valid, input evt_t e);
    logic [7:0] b;
    b = '0;
    if (valid) begin
      b[INFO_VALID_BIT]           = 1'b1;
      b[INFO_TYPE_BIT]            = e.evt_type;
      b[INFO_DIR_BIT]             = e.dir;
      b[INFO_SW_BIT]              = e.sw;
      b[INFO_CH_LSB +: CH_W]      = e.ch;
    end
    return b;
  endfunction

endpackage

// File: rtl/rotary_scanner_fifo.sv
// Event queue shared by all scanner channels: synchronous FIFO with push, pop and flush.
// Pop is ignored when empty; push while full is accepted only together with a pop.
module rotary_scanner_fifo
  import rotary_scanner_pkg::*;
#(
  parameter int DEPTH = 8
) (
  input  logic clk,
  input  logic reset_n,
  input  logic push_i,
  input  logic pop_i,
  input  logic flush_i,
  input  evt_t din_i,
  output evt_t head_o,
  output logic full_o,
  output logic empty_o
);

  localparam int AW = $clog2(DEPTH);

  evt_t          mem_q [DEPTH];
  logic [AW-1:0] wptr_q, rptr_q;
  logic [AW:0]   count_q, count_d;
  logic          do_push, do_pop;

  assign full_o  = (count_q == (AW+1)'(DEPTH));
  assign empty_o = (count_q == '0);
  assign head_o  = mem_q[rptr_q];

  always_comb begin
    do_pop  = pop_i & ~empty_o & ~flush_i;
    do_push = push_i & (~full_o | do_pop) & ~flush_i;
    count_d = count_q;
    if (flush_i) begin
      count_d = '0;
    end else if (do_push && !do_pop) begin
      count_d = count_q + (AW+1)'(1);
    end else if (do_pop && !do_push) begin
      count_d = count_q - (AW+1)'(1);
    end
  end

  always_ff @(posedge clk) begin
    if (!reset_n) begin
      wptr_q  <= '0;
      rptr_q  <= '0;
      count_q <= '0;
    end else begin
      count_q <= count_d;
      if (flush_i) begin
        wptr_q <= '0;
        rptr_q <= '0;
      end else begin
        if (do_push) wptr_q <= wptr_q + AW'(1);
        if (do_pop)  rptr_q <= rptr_q + AW'(1);
      end
    end
  end

  always_ff @(posedge clk) begin
    if (reset_n && do_push) mem_q[wptr_q] <= din_i;
  end

endmodule

// File: rtl/rotary_encoder_scanner.sv
// Multi-channel rotary encoder event scanner: change detection, round-robin queueing, CPU drain regs.
// Optional: define ROTARY_SCANNER_SW_EVENT_EN to raise events on switch-level changes (type=1).
module rotary_encoder_scanner
  import rotary_scanner_pkg::*;
#(
  parameter int NUM_CH             = 4,
  parameter int COUNTER_BITS       = 8,
  parameter int FIFO_DEPTH         = 8,
  parameter int DATA_WIDTH         = 8,
  parameter int REG_ADDR_EVT_INFO  = 0,
  parameter int REG_ADDR_EVT_VALUE = 1,
  parameter int REG_ADDR_MASK      = 2,
  parameter int REG_ADDR_CTRL      = 3
) (
  input  logic                           clk,
  input  logic                           reset_n,
  input  logic                           stb_i,
  input  logic                           we_i,
  input  logic [DATA_WIDTH-1:0]          adr_wr_i,
  input  logic [DATA_WIDTH-1:0]          adr_rd_i,
  input  logic [DATA_WIDTH-1:0]          dat_i,
  output logic [DATA_WIDTH-1:0]          dat_o,
  output logic                           ack_o,
  input  logic [NUM_CH*COUNTER_BITS-1:0] counter_in,
  input  logic [NUM_CH-1:0]              sw_in,
  output logic                           int_o
);

  logic                    wr_en_q;
  logic [DATA_WIDTH-1:0]   wr_adr_q, wr_dat_q;
  logic [NUM_CH-1:0]       mask_q, pend_q, shadow_sw_q;
  logic [COUNTER_BITS-1:0] shadow_val_q [NUM_CH];
  logic                    int_en_q, primed_q, int_q;
  logic [CH_W-1:0]         last_grant_q;

  logic [COUNTER_BITS-1:0] cnt [MAX_CH];
  logic [COUNTER_BITS-1:0] shd [MAX_CH];
  logic [MAX_CH-1:0]       sw_vec, val_chg, sw_chg, chg, req;
  logic [CH_W-1:0]         scan_idx, gnt_ch;
  logic                    gnt_valid, push, pop, flush, rd_value_hit;
  logic [COUNTER_BITS-1:0] delta;
  logic                    fifo_full, fifo_empty;
  evt_t                    evt_d, head;
  logic [7:0]              info;
  logic                    unused_sig;

  assign ack_o        = stb_i;
  assign int_o        = int_q;
  assign flush        = wr_en_q && (wr_adr_q == DATA_WIDTH'(REG_ADDR_CTRL)) && wr_dat_q[CTRL_FLUSH_BIT];
  assign rd_value_hit = stb_i && !we_i && (adr_rd_i == DATA_WIDTH'(REG_ADDR_EVT_VALUE));
  assign unused_sig   = ^{wr_dat_q, sw_chg, head.value};

  // Per-channel view widened to MAX_CH so the 3-bit channel index can address it directly.
  always_comb begin
    cnt     = '{default: '0};
    shd     = '{default: '0};
    sw_vec  = '0;
    val_chg = '0;
    sw_chg  = '0;
    chg     = '0;
    req     = '0;
    for (int k = 0; k < NUM_CH; k++) begin
      cnt[k]     = counter_in[k*COUNTER_BITS +: COUNTER_BITS];
      shd[k]     = shadow_val_q[k];
      sw_vec[k]  = sw_in[k];
      val_chg[k] = (cnt[k] != shd[k]);
      sw_chg[k]  = (sw_in[k] != shadow_sw_q[k]);
`ifdef ROTARY_SCANNER_SW_EVENT_EN
      chg[k]     = val_chg[k] | sw_chg[k];
`else
      chg[k]     = val_chg[k];
`endif
      req[k]     = primed_q & mask_q[k] & (pend_q[k] | chg[k]);
    end
  end

  always_comb begin
    gnt_valid = 1'b0;
    gnt_ch    = '0;
    scan_idx  = '0;
    pop       = rd_value_hit & ~fifo_empty & ~flush;
    for (int i = 0; i < NUM_CH; i++) begin
      scan_idx = CH_W'((32'(last_grant_q) + 32'(i) + 32'd1) % 32'(NUM_CH));
      if (!gnt_valid && req[scan_idx]) begin
        gnt_valid = 1'b1;
        gnt_ch    = scan_idx;
      end
    end
    // A full queue only delays a grant; a same-cycle pop frees the slot.
    if (flush || (fifo_full && !pop)) gnt_valid = 1'b0;
    push = gnt_valid;
  end

  always_comb begin
    evt_d       = '0;
    delta       = cnt[gnt_ch] - shd[gnt_ch];
    evt_d.ch    = gnt_ch;
    evt_d.value = EVT_VALUE_W'(cnt[gnt_ch]);
    evt_d.sw    = sw_vec[gnt_ch];
    evt_d.dir   = (delta != '0) && !delta[COUNTER_BITS-1];
`ifdef ROTARY_SCANNER_SW_EVENT_EN
    evt_d.evt_type = !val_chg[gnt_ch] && sw_chg[gnt_ch];
`endif
  end

  rotary_scanner_fifo #(
    .DEPTH (FIFO_DEPTH)
  ) u_fifo (
    .clk     (clk),
    .reset_n (reset_n),
    .push_i  (push),
    .pop_i   (pop),
    .flush_i (flush),
    .din_i   (evt_d),
    .head_o  (head),
    .full_o  (fifo_full),
    .empty_o (fifo_empty)
  );

  assign info = info_byte(~fifo_empty, head);

  always_comb begin
    dat_o = '0;
    if (adr_rd_i == DATA_WIDTH'(REG_ADDR_EVT_INFO)) begin
      dat_o = DATA_WIDTH'(info);
    end else if (adr_rd_i == DATA_WIDTH'(REG_ADDR_EVT_VALUE) && !fifo_empty) begin
      dat_o = DATA_WIDTH'(head.value);
    end
  end

  always_ff @(posedge clk) begin
    if (!reset_n) begin
      wr_en_q      <= 1'b0;
      wr_adr_q     <= '0;
      wr_dat_q     <= '0;
      mask_q       <= '0;
      int_en_q     <= 1'b0;
      primed_q     <= 1'b0;
      int_q        <= 1'b0;
      pend_q       <= '0;
      shadow_sw_q  <= '0;
      last_grant_q <= CH_W'(NUM_CH-1);
      for (int k = 0; k < NUM_CH; k++) shadow_val_q[k] <= '0;
    end else begin
      wr_en_q  <= stb_i & we_i;
      wr_adr_q <= adr_wr_i;
      wr_dat_q <= dat_i;
      primed_q <= 1'b1;
      int_q    <= int_en_q & ~fifo_empty;
      if (gnt_valid) last_grant_q <= gnt_ch;
      if (wr_en_q && wr_adr_q == DATA_WIDTH'(REG_ADDR_MASK)) mask_q <= wr_dat_q[NUM_CH-1:0];
      if (wr_en_q && wr_adr_q == DATA_WIDTH'(REG_ADDR_CTRL)) int_en_q <= wr_dat_q[CTRL_INT_EN_BIT];
      // Priming, disabled channels, flush and grant all resync the shadow without raising an event.
      for (int k = 0; k < NUM_CH; k++) begin
        if (!primed_q || !mask_q[k] || flush || (gnt_valid && gnt_ch == CH_W'(k))) begin
          shadow_val_q[k] <= cnt[k];
          shadow_sw_q[k]  <= sw_in[k];
          pend_q[k]       <= 1'b0;
        end else if (chg[k]) begin
          pend_q[k] <= 1'b1;
        end
      end
    end
  end

endmodule

// File: tb/tb_rotary_encoder_scanner.sv
// Self-checking bench for rotary_encoder_scanner: directed scenarios then randomized traffic
// against a queue-based reference model of the event rules.
module tb_rotary_encoder_scanner;

  localparam int NUM_CH = 4;
  localparam int DEPTH  = 8;
  localparam logic [7:0] A_INFO  = 8'h00;
  localparam logic [7:0] A_VALUE = 8'h01;
  localparam logic [7:0] A_MASK  = 8'h02;
  localparam logic [7:0] A_CTRL  = 8'h03;
`ifdef ROTARY_SCANNER_SW_EVENT_EN
  localparam bit SW_EV = 1'b1;
`else
  localparam bit SW_EV = 1'b0;
`endif

  logic        clk = 1'b0;
  logic        reset_n = 1'b0;
  logic        stb_i = 1'b0, we_i = 1'b0;
  logic [7:0]  adr_wr_i = '0, adr_rd_i = '0, dat_i = '0;
  logic [7:0]  dat_o;
  logic        ack_o, int_o;
  logic [31:0] counter_in;
  logic [3:0]  sw_v = '0;
  logic [7:0]  cnt [NUM_CH];

  int n_checks = 0;
  int n_errors = 0;

  typedef struct { logic [7:0] info; logic [7:0] value; } mevt_t;
  mevt_t      mq[$];
  logic [7:0] m_rep_val [NUM_CH];
  logic [3:0] m_rep_sw, m_pend, m_mask;
  bit         m_int_en, m_primed, m_int, m_wr_v;
  logic [7:0] m_wr_adr, m_wr_dat;
  int         m_last;

  assign counter_in = {cnt[3], cnt[2], cnt[1], cnt[0]};

  always #5 clk = ~clk;

  rotary_encoder_scanner #(
    .NUM_CH(NUM_CH), .COUNTER_BITS(8), .FIFO_DEPTH(DEPTH), .DATA_WIDTH(8),
    .REG_ADDR_EVT_INFO(0), .REG_ADDR_EVT_VALUE(1), .REG_ADDR_MASK(2), .REG_ADDR_CTRL(3)
  ) dut (
    .clk(clk), .reset_n(reset_n), .stb_i(stb_i), .we_i(we_i),
    .adr_wr_i(adr_wr_i), .adr_rd_i(adr_rd_i), .dat_i(dat_i), .dat_o(dat_o),
    .ack_o(ack_o), .counter_in(counter_in), .sw_in(sw_v), .int_o(int_o)
  );

  task automatic check_eq(input string tag, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_errors++;
      $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", tag, act, exp, $time);
    end
  endtask

  function automatic mevt_t make_evt(int k);
    mevt_t e;
    int    d;
    bit    typ, dir;
    d   = (int'(cnt[k]) - int'(m_rep_val[k]) + 256) % 256;
    dir = (d > 0) && (d < 128);
    typ = SW_EV && (cnt[k] == m_rep_val[k]) && (sw_v[k] != m_rep_sw[k]);
    e.info  = {1'b1, typ, dir, sw_v[k], 1'b0, 3'(k)};
    e.value = cnt[k];
    return e;
  endfunction

  // Applies the event rules for the clock edge about to happen, using the inputs now applied.
  task automatic model_edge();
    bit flush, pop, int_next, chg;
    bit [3:0] want;
    int g;
    if (!reset_n) begin
      mq.delete();
      m_mask = '0; m_int_en = 0; m_primed = 0; m_int = 0; m_last = NUM_CH - 1;
      m_wr_v = 0; m_wr_adr = '0; m_wr_dat = '0; m_rep_sw = '0; m_pend = '0;
      for (int k = 0; k < NUM_CH; k++) m_rep_val[k] = '0;
      return;
    end
    flush    = m_wr_v && (m_wr_adr == A_CTRL) && m_wr_dat[1];
    pop      = stb_i && !we_i && (adr_rd_i == A_VALUE) && (mq.size() > 0) && !flush;
    int_next = m_int_en && (mq.size() != 0);
    want = '0;
    for (int k = 0; k < NUM_CH; k++) begin
      chg = (cnt[k] != m_rep_val[k]) || (SW_EV && (sw_v[k] != m_rep_sw[k]));
      want[k] = m_primed && m_mask[k] && (m_pend[k] || chg);
    end
    g = -1;
    if (!flush && (mq.size() < DEPTH || pop))
      for (int j = 1; j <= NUM_CH; j++)
        if (g < 0 && want[(m_last + j) % NUM_CH]) g = (m_last + j) % NUM_CH;
    if (flush) mq.delete();
    else begin
      if (pop) void'(mq.pop_front());
      if (g >= 0) mq.push_back(make_evt(g));
    end
    for (int k = 0; k < NUM_CH; k++) begin
      chg = (cnt[k] != m_rep_val[k]) || (SW_EV && (sw_v[k] != m_rep_sw[k]));
      if (!m_primed || !m_mask[k] || flush || g == k) begin
        m_rep_val[k] = cnt[k]; m_rep_sw[k] = sw_v[k]; m_pend[k] = 1'b0;
      end else if (chg) m_pend[k] = 1'b1;
    end
    if (g >= 0) m_last = g;
    if (m_wr_v && m_wr_adr == A_MASK) m_mask = m_wr_dat[3:0];
    if (m_wr_v && m_wr_adr == A_CTRL) m_int_en = m_wr_dat[0];
    m_primed = 1; m_int = int_next;
    m_wr_v = stb_i && we_i; m_wr_adr = adr_wr_i; m_wr_dat = dat_i;
  endtask

  task automatic verify();
    logic [7:0] ei, ev;
    ei = (mq.size() != 0) ? mq[0].info  : 8'h00;
    ev = (mq.size() != 0) ? mq[0].value : 8'h00;
    check_eq("int_o", int_o, m_int);
    stb_i = 1'b0; we_i = 1'b0;
    adr_rd_i = A_INFO;  #1; check_eq("info", dat_o, ei);
    adr_rd_i = A_VALUE; #1; check_eq("value", dat_o, ev);
    adr_rd_i = 8'h10 + 8'($urandom_range(0, 15)); stb_i = 1'b1; #1;
    check_eq("unmapped", dat_o, 8'h00);
    check_eq("ack", ack_o, 1'b1);
    stb_i = 1'b0; #1;
  endtask

  task automatic step();
    model_edge();
    @(posedge clk); #1;
    verify();
  endtask

  task automatic peek(input logic [7:0] a, output logic [7:0] v);
    adr_rd_i = a; #1; v = dat_o;
  endtask

  task automatic bus_write(input logic [7:0] a, input logic [7:0] d);
    stb_i = 1'b1; we_i = 1'b1; adr_wr_i = a; dat_i = d;
    step();
  endtask

  task automatic read_pop();
    stb_i = 1'b1; we_i = 1'b0; adr_rd_i = A_VALUE;
    step();
  endtask

  initial begin
    #2000000;
    $display("FAIL watchdog: simulation did not finish in time");
    $fatal(1, "watchdog");
  end

  initial begin
    logic [7:0] v;
    int rd_pct, r, ch;
    for (int k = 0; k < NUM_CH; k++) cnt[k] = 8'h10;
    reset_n = 1'b0;
    step(); step();
    reset_n = 1'b1;
    step();
    bus_write(A_MASK, 8'h0F);
    step(); step(); step();
    peek(A_INFO, v); check_eq("enable_no_evt", v, 8'h00);
    check_eq("enable_no_int", int_o, 1'b0);

    bus_write(A_CTRL, 8'h01); step();
    cnt[2] = 8'h11; #1; cnt[2] = 8'h12; #1; cnt[2] = 8'h13;
    step();
    peek(A_INFO, v);  check_eq("coalesce_info", v, 8'hA2);
    peek(A_VALUE, v); check_eq("coalesce_value", v, 8'h13);
    step();
    check_eq("int_set", int_o, 1'b1);
    read_pop(); step();
    check_eq("int_clear", int_o, 1'b0);

    cnt[1] = 8'h11; step();
    read_pop();
    cnt[1] = 8'h12; cnt[3] = 8'h11; step();
    peek(A_INFO, v); check_eq("rr_first_ch3", v, 8'hA3);
    step();
    read_pop();
    peek(A_INFO, v); check_eq("rr_second_ch1", v, 8'hA1);
    read_pop();

    for (int i = 0; i < DEPTH; i++) begin cnt[i % NUM_CH] += 8'd1; step(); end
    cnt[0] += 8'd1; step();
    peek(A_INFO, v); check_eq("full_head_ch0", v[2:0], 3'd0);
    read_pop();
    for (int i = 0; i < DEPTH - 1; i++) read_pop();
    peek(A_VALUE, v); check_eq("pending_pushed_value", v, cnt[0]);
    read_pop();
    peek(A_INFO, v); check_eq("drained_empty", v, 8'h00);

    cnt[0] = 8'h00; step(); read_pop();
    cnt[0] = 8'hFF; step();
    peek(A_INFO, v); check_eq("dir_down_ff", v, 8'h80);
    read_pop();
    cnt[0] = 8'h00; step();
    peek(A_INFO, v); check_eq("dir_up_wrap", v, 8'hA0);
    read_pop();

    sw_v[1] = 1'b1; step();
    peek(A_INFO, v); check_eq("sw_event", v, SW_EV ? 8'hD1 : 8'h00);
    cnt[2] += 8'd1; step();
    bus_write(A_CTRL, 8'h03); step();
    peek(A_INFO, v);  check_eq("flush_info", v, 8'h00);
    peek(A_VALUE, v); check_eq("flush_value", v, 8'h00);

    rd_pct = 20;
    for (int c = 0; c < 3000; c++) begin
      if (c % 250 == 0) rd_pct = $urandom_range(3, 70);
      if (c == 1500) begin
        reset_n = 1'b0; step(); step(); reset_n = 1'b1;
      end
      if ($urandom_range(0, 99) < 30) begin
        ch = $urandom_range(0, NUM_CH - 1);
        case ($urandom_range(0, 3))
          0: cnt[ch] += 8'($urandom_range(1, 3));
          1: cnt[ch] -= 8'($urandom_range(1, 3));
          2: cnt[ch] = 8'($urandom);
          default: cnt[ch] += 8'd1;
        endcase
      end
      if ($urandom_range(0, 99) < 3) begin
        ch = $urandom_range(0, NUM_CH - 1);
        sw_v[ch] = ~sw_v[ch];
      end
      r = $urandom_range(0, 99);
      if (r < 2) begin
        stb_i = 1'b1; we_i = 1'b1; adr_wr_i = A_MASK;
        dat_i = ($urandom_range(0, 2) != 0) ? 8'h0F : 8'($urandom);
      end else if (r < 3) begin
        stb_i = 1'b1; we_i = 1'b1; adr_wr_i = A_CTRL;
        dat_i = {6'b0, 1'($urandom_range(0, 3) == 0), 1'($urandom_range(0, 4) != 0)};
      end else if (r < 3 + rd_pct) begin
        stb_i = 1'b1; we_i = 1'b0; adr_rd_i = A_VALUE;
      end else if (r < 8 + rd_pct) begin
        stb_i = 1'b1; we_i = 1'b0; adr_rd_i = A_INFO;
      end else begin
        adr_rd_i = 8'($urandom_range(0, 7));
      end
      step();
    end

    $display("CHECKS %0d ERRORS %0d", n_checks, n_errors);
    $finish;
  end

endmodule
